add_sub_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface, per-operation add/sub and wrap/saturate mode, and correct carry, signed-overflow and zero flags. Operand width is split into fixed-width segments, one segment per pipeline stage with a registered carry between stages, so the design reaches a full-rate clock at large widths. It is the arithmetic datapath element for the ALU and accumulator blocks, and replaces the combinational add/sub used so far.

---
 rtl/add_sub_pkg.sv | 24 ++
 rtl/add_sub_pipe_if.sv | 27 ++
 rtl/add_seg_stage.sv | 47 ++++
 rtl/add_sub_pipe.sv | 122 ++++++++++++
 tb/tb_add_sub_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared constants and helpers for the segmented add/sub pipeline
package add_sub_pkg;

    localparam int FLAG_COUT = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_W    = 3;

    // Saturation constants are built at this width and truncated to N by the user.
    localparam int MAX_W = 64;

    function automatic int seg_count(input int n, input int seg);
        return n / seg;
    endfunction

    function automatic logic [MAX_W-1:0] max_pos(input int n);
        return (MAX_W'(1) << (n - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] max_neg(input int n);
        return MAX_W'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// rtl/add_sub_pipe_if.sv - operand/result stream bundle for add_sub_pipe
interface add_sub_pipe_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, sub, sat, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, sat, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/add_seg_stage.sv
// rtl/add_seg_stage.sv - one SEG-bit adder slice with registered sum, carry, valid and side-band context
module add_seg_stage #(
    parameter int SEG = 4,
    parameter int W   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic           valid_i,
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           c_i,
    input  logic [W-1:0]   ctx_i,
    output logic           valid_o,
    output logic [SEG-1:0] sum_o,
    output logic           c_o,
    output logic [W-1:0]   ctx_o
);

    logic [SEG:0]   total_d;
    logic           valid_q;
    logic [SEG-1:0] sum_q;
    logic           c_q;
    logic [W-1:0]   ctx_q;

    assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, c_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            ctx_q   <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= total_d[SEG-1:0];
            c_q     <= total_d[SEG];
            ctx_q   <= ctx_i;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign c_o     = c_q;
    assign ctx_o   = ctx_q;

endmodule

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - segmented, globally stalled two's-complement add/sub with wrap/saturate and flags
module add_sub_pipe #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic           clk,
    input  logic           rst,
    add_sub_pipe_if.slave  bus
);
    import add_sub_pkg::*;

    localparam int STAGES = seg_count(N, SEG);
    localparam int L      = STAGES - 1;
    localparam int CTX_W  = 3 * N + 1;
    localparam logic [N-1:0] SAT_POS = N'(max_pos(N));
    localparam logic [N-1:0] SAT_NEG = N'(max_neg(N));

    logic advance;
    logic in_ready;

    logic [N-1:0]     a_in   [STAGES];
    logic [N-1:0]     b_in   [STAGES];
    logic [N-1:0]     r_in   [STAGES];
    logic             sat_in [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];

    logic [N-1:0]     a_out   [STAGES];
    logic [N-1:0]     b_out   [STAGES];
    logic [N-1:0]     r_out   [STAGES];
    logic             sat_out [STAGES];
    logic             c_out   [STAGES];
    logic             v_out   [STAGES];
    logic [SEG-1:0]   sum_out [STAGES];
    logic [CTX_W-1:0] ctx_out [STAGES];

    logic              out_valid_q;
    logic [N-1:0]      s_q;
    logic [N-1:0]      s_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [N-1:0]      raw;
    logic              ovf_d;

    assign advance  = !out_valid_q || bus.out_ready;
    assign in_ready = advance && !rst;

    // Each token carries its operands and the result segments finished so far;
    // stage k fills segment k, so lower result bits are ORed into a zeroed field.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = bus.a;
            assign b_in[k]   = bus.b ^ {N{bus.sub}};
            assign r_in[k]   = '0;
            assign sat_in[k] = bus.sat;
            assign c_in[k]   = bus.sub;
            assign v_in[k]   = bus.in_valid && in_ready;
        end else begin : g_link
            assign a_in[k]   = a_out[k-1];
            assign b_in[k]   = b_out[k-1];
            assign r_in[k]   = r_out[k-1] | (N'(sum_out[k-1]) << ((k - 1) * SEG));
            assign sat_in[k] = sat_out[k-1];
            assign c_in[k]   = c_out[k-1];
            assign v_in[k]   = v_out[k-1];
        end

        add_seg_stage #(
            .SEG (SEG),
            .W   (CTX_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (advance),
            .valid_i (v_in[k]),
            .a_i     (a_in[k][k*SEG +: SEG]),
            .b_i     (b_in[k][k*SEG +: SEG]),
            .c_i     (c_in[k]),
            .ctx_i   ({sat_in[k], r_in[k], b_in[k], a_in[k]}),
            .valid_o (v_out[k]),
            .sum_o   (sum_out[k]),
            .c_o     (c_out[k]),
            .ctx_o   (ctx_out[k])
        );

        assign {sat_out[k], r_out[k], b_out[k], a_out[k]} = ctx_out[k];
    end

    always_comb begin
        raw     = r_out[L] | (N'(sum_out[L]) << (L * SEG));
        ovf_d   = (a_out[L][N-1] == b_out[L][N-1]) && (raw[N-1] != a_out[L][N-1]);
        s_d     = raw;
        if (sat_out[L] && ovf_d) begin
            s_d = a_out[L][N-1] ? SAT_NEG : SAT_POS;
        end
        flags_d            = '0;
        flags_d[FLAG_COUT] = c_out[L];
        flags_d[FLAG_OVF]  = ovf_d;
        flags_d[FLAG_ZERO] = (s_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            flags_q     <= '0;
        end else if (advance) begin
            out_valid_q <= v_out[L];
            if (v_out[L]) begin
                s_q     <= s_d;
                flags_q <= flags_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = flags_q[FLAG_COUT];
    assign bus.ovf       = flags_q[FLAG_OVF];
    assign bus.zero      = flags_q[FLAG_ZERO];

endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - directed and randomized self-checking bench for add_sub_pipe
module tb_add_sub_pipe;

    localparam int N   = 16;
    localparam int SEG = 4;
    localparam int LAT = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    add_sub_pipe_if #(.N(N)) bus ();

    add_sub_pipe #(
        .N   (N),
        .SEG (SEG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic sat);
        res_t o;
        int   sa;
        int   sb;
        int   r;
        sa     = $signed(a);
        sb     = $signed(b);
        r      = sub ? sa - sb : sa + sb;
        o.ovf  = (r > 32767) || (r < -32768);
        o.cout = sub ? (a >= b) : ((int'(a) + int'(b)) > 65535);
        if (o.ovf && sat) o.s = (r > 0) ? 16'h7FFF : 16'h8000;
        else              o.s = 16'(r);
        o.zero = (o.s == 16'h0000);
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_single(input string tag, input logic [15:0] av, input logic [15:0] bv,
                              input logic sv, input logic tv, input logic [15:0] es,
                              input logic ec, input logic eo, input logic ez);
        int cyc;
        bus.in_valid  = 1'b1;
        bus.a         = av;
        bus.b         = bv;
        bus.sub       = sv;
        bus.sat       = tv;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "/latency"}, 32'(cyc), 32'(LAT));
        check({tag, "/s"},    32'(bus.s),    32'(es));
        check({tag, "/cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "/ovf"},  32'(bus.ovf),  32'(eo));
        check({tag, "/zero"}, 32'(bus.zero), 32'(ez));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t        expq[$];
        res_t        e;
        logic [15:0] ra[8];
        logic [15:0] rb[8];
        logic        rs[8];
        logic        rt[8];
        logic [18:0] held;
        logic        stalled;
        logic        acc;
        int          sent;
        int          got;
        int          cyc;
        int          nstall;
        int          seen;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.sat       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs",   32'({bus.s, bus.cout, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_single("add_ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_single("add_ovf_sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_single("sub_neg_wrap", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_single("sub_neg_sat",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_single("sub_ovf_wrap", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_single("sub_ovf_sat",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        run_single("wrap_zero",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_single("wrap_zero_sat",16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_single("sub_zero",     16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_single("neg_sat_nz",   16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Consumer stalled with an empty pipeline: input side must stay open.
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h0001;
        bus.sub = 1'b0;
        bus.sat = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bubble_latency", 32'(cyc), 32'(LAT));
        check("bubble_blocked", 32'(bus.in_ready), 32'd0);
        check("bubble_s", 32'(bus.s), 32'h1235);
        @(posedge clk); #1;
        check("bubble_hold", 32'({bus.out_valid, bus.s}), 32'h11235);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bubble_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back random burst with a 3-cycle consumer stall.
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
            rs[i] = 1'($urandom);
            rt[i] = 1'($urandom);
        end
        sent = 0;
        got = 0;
        cyc = 0;
        nstall = 0;
        stalled = 1'b0;
        held = '0;
        while (got < 8 && cyc < 60) begin
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.a   = ra[sent];
                bus.b   = rb[sent];
                bus.sub = rs[sent];
                bus.sat = rt[sent];
            end
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                nstall++;
                check("burst_stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            if (stalled && bus.out_valid)
                check("burst_hold", 32'({bus.s, bus.cout, bus.ovf, bus.zero}), 32'(held));
            stalled = bus.out_valid && !bus.out_ready;
            held = {bus.s, bus.cout, bus.ovf, bus.zero};
            acc = bus.in_valid && bus.in_ready;
            if (acc) expq.push_back(model(bus.a, bus.b, bus.sub, bus.sat));
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    check("burst_spurious", 32'd1, 32'(got));
                end else begin
                    e = expq.pop_front();
                    check("burst_s", 32'(bus.s), 32'(e.s));
                    check("burst_flags", 32'({bus.cout, bus.ovf, bus.zero}),
                          32'({e.cout, e.ovf, e.zero}));
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        check("burst_count", 32'(got), 32'd8);
        check("burst_stall_cycles", 32'(nstall), 32'd3);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three tokens in flight.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
            bus.sub = 1'($urandom);
            bus.sat = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
        check("midrst_outputs",   32'({bus.s, bus.cout, bus.ovf, bus.zero}), 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        check("midrst_outputs_idle", 32'({bus.s, bus.cout, bus.ovf, bus.zero}), 32'd0);
        run_single("post_rst_add", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
